// File: rtl/vecdiv_sequencer.sv
// vecdiv_sequencer
//   Runs one vector-divide job over a shared dual-port RAM: for each element i it reads
//   A[i] (port 1) and B[i] (port 2), launches an external multi-cycle divider and writes
//   Q[i] = A[i] / B[i] back through port 1. A zero divisor skips the divider, writes
//   all-ones and is counted in dz_count.
// Ports
//   clock, reset_n                  clock (rising edge) and async active-low reset
//   start, len, base_a/b/q          job request and parameters, latched when accepted in IDLE
//   busy, done, dz_count            job status: busy during the job, 1-cycle done pulse,
//                                   divide-by-zero count of the current/last job
//   ram_addr1/wdata1/we1/rdata1     RAM port 1 (read A, write Q)
//   ram_addr2/rdata2                RAM port 2 (read B)
//   div_start/dividend/divisor      divider launch pulse and operands
//   div_done/quotient               divider result handshake
module vecdiv_sequencer #(
  parameter int unsigned RAMSIZE   = 1924,
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRW     = $clog2(RAMSIZE)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDRW:0]       len,
  input  logic [ADDRW-1:0]     base_a,
  input  logic [ADDRW-1:0]     base_b,
  input  logic [ADDRW-1:0]     base_q,
  output logic                 busy,
  output logic                 done,
  output logic [ADDRW:0]       dz_count,
  output logic [ADDRW-1:0]     ram_addr1,
  output logic [DATAWIDTH-1:0] ram_wdata1,
  output logic                 ram_we1,
  input  logic [DATAWIDTH-1:0] ram_rdata1,
  output logic [ADDRW-1:0]     ram_addr2,
  input  logic [DATAWIDTH-1:0] ram_rdata2,
  output logic                 div_start,
  output logic [DATAWIDTH-1:0] div_dividend,
  output logic [DATAWIDTH-1:0] div_divisor,
  input  logic                 div_done,
  input  logic [DATAWIDTH-1:0] div_quotient
);

  typedef enum logic [2:0] {
    StIdle, StRd, StLaunch, StIssue, StDiv, StWr, StDone
  } state_e;

  state_e               state_q, state_d;
  logic [ADDRW:0]       len_q, len_d;
  logic [ADDRW-1:0]     ba_q, ba_d;
  logic [ADDRW-1:0]     bb_q, bb_d;
  logic [ADDRW-1:0]     bq_q, bq_d;
  logic [ADDRW:0]       idx_q, idx_d;
  logic [ADDRW:0]       dz_q, dz_d;
  logic [DATAWIDTH-1:0] opa_q, opa_d;
  logic [DATAWIDTH-1:0] opb_q, opb_d;
  logic [DATAWIDTH-1:0] quot_q, quot_d;
  logic [ADDRW:0]       idx_inc;

  assign idx_inc = idx_q + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      ba_q    <= '0;
      bb_q    <= '0;
      bq_q    <= '0;
      idx_q   <= '0;
      dz_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      quot_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ba_q    <= ba_d;
      bb_q    <= bb_d;
      bq_q    <= bq_d;
      idx_q   <= idx_d;
      dz_q    <= dz_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      quot_q  <= quot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ba_d    = ba_q;
    bb_d    = bb_q;
    bq_d    = bq_q;
    idx_d   = idx_q;
    dz_d    = dz_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    quot_d  = quot_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = len;
          ba_d    = base_a;
          bb_d    = base_b;
          bq_d    = base_q;
          idx_d   = '0;
          dz_d    = '0;
          state_d = (len != '0) ? StRd : StDone;
        end
      end
      StRd: state_d = StLaunch;
      StLaunch: begin
        opa_d = ram_rdata1;
        opb_d = ram_rdata2;
        // Zero divisor bypasses the divider entirely.
        if (ram_rdata2 == '0) begin
          quot_d  = '1;
          dz_d    = dz_q + 1'b1;
          state_d = StWr;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: state_d = StDiv;
      StDiv: begin
        if (div_done) begin
          quot_d  = div_quotient;
          state_d = StWr;
        end
      end
      StWr: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == len_q) ? StDone : StRd;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // All outputs decode from state and registers only.
  always_comb begin
    busy         = (state_q == StRd) || (state_q == StLaunch) || (state_q == StIssue) ||
                   (state_q == StDiv) || (state_q == StWr);
    done         = (state_q == StDone);
    dz_count     = dz_q;
    ram_addr1    = '0;
    ram_addr2    = '0;
    ram_wdata1   = '0;
    ram_we1      = 1'b0;
    div_start    = (state_q == StIssue);
    div_dividend = opa_q;
    div_divisor  = opb_q;
    if (state_q == StRd) begin
      // Address arithmetic wraps modulo 2^ADDRW.
      ram_addr1 = ba_q + idx_q[ADDRW-1:0];
      ram_addr2 = bb_q + idx_q[ADDRW-1:0];
    end
    if (state_q == StWr) begin
      ram_addr1  = bq_q + idx_q[ADDRW-1:0];
      ram_wdata1 = quot_q;
      ram_we1    = 1'b1;
    end
  end

endmodule

// File: tb/tb_vecdiv_sequencer.sv
// tb_vecdiv_sequencer
//   Directed bench for vecdiv_sequencer: behavioural dual-port RAM with 1-cycle read
//   latency, behavioural divider with a per-job latency, table of jobs with hand-computed
//   quotients, plus hand-written sequences for len=0, held start and reset mid-divide.
module tb_vecdiv_sequencer;
  localparam int ADDRW = 11;
  localparam int DW    = 32;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [ADDRW:0]   len = '0;
  logic [ADDRW-1:0] base_a = '0, base_b = '0, base_q = '0;
  logic             busy, done;
  logic [ADDRW:0]   dz_count;
  logic [ADDRW-1:0] ram_addr1, ram_addr2;
  logic [DW-1:0]    ram_wdata1, ram_rdata1, ram_rdata2;
  logic             ram_we1, div_start, div_done;
  logic [DW-1:0]    div_dividend, div_divisor, div_quotient;

  vecdiv_sequencer #(.RAMSIZE(1924), .DATAWIDTH(DW), .ADDRW(ADDRW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .len(len),
    .base_a(base_a), .base_b(base_b), .base_q(base_q),
    .busy(busy), .done(done), .dz_count(dz_count),
    .ram_addr1(ram_addr1), .ram_wdata1(ram_wdata1), .ram_we1(ram_we1),
    .ram_rdata1(ram_rdata1), .ram_addr2(ram_addr2), .ram_rdata2(ram_rdata2),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient)
  );

  always #5 clock = ~clock;

  // RAM model: 2^ADDRW words so wrapped addresses are reachable; bench preload port.
  logic [DW-1:0]    mem [0:(1<<ADDRW)-1];
  logic             pre_we = 1'b0;
  logic [ADDRW-1:0] pre_addr = '0;
  logic [DW-1:0]    pre_data = '0;
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we1) mem[ram_addr1] <= ram_wdata1;
    ram_rdata1 <= mem[ram_addr1];
    ram_rdata2 <= mem[ram_addr2];
  end

  // Divider model: div_done in the k-th cycle after the launch pulse.
  int            div_k = 3;
  int            dv_cnt = 0;
  logic [DW-1:0] dv_a = '0, dv_b = '0;
  always @(posedge clock) begin
    if (div_start) begin
      dv_cnt <= div_k;
      dv_a   <= div_dividend;
      dv_b   <= div_divisor;
    end else if (dv_cnt > 0) begin
      dv_cnt <= dv_cnt - 1;
    end
  end
  assign div_done     = (dv_cnt == 1);
  assign div_quotient = (dv_b != 0) ? dv_a / dv_b : '1;

  // Event counters, sampled mid-cycle.
  int n_div = 0, n_done = 0, n_we = 0, n_busy = 0;
  always @(negedge clock) begin
    if (div_start) n_div++;
    if (done) n_done++;
    if (ram_we1) n_we++;
    if (busy) n_busy++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [ADDRW:0]      len;
    logic [ADDRW-1:0]    ba;
    logic [ADDRW-1:0]    bb;
    logic [ADDRW-1:0]    bq;
    logic [3:0][DW-1:0]  a;     // concatenations list element 3 down to element 0
    logic [3:0][DW-1:0]  b;
    logic [3:0][DW-1:0]  q;
    logic [7:0]          k;
    logic [ADDRW:0]      dz;
    logic [7:0]          ndiv;
    logic [7:0]          cyc;   // expected busy cycles for the whole job
  } vec_t;

  vec_t vecs [5];

  task automatic ram_write(input logic [ADDRW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clock);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  // Q first so in-place jobs end up with the real operands.
  task automatic preload(input vec_t v);
    for (int i = 0; i < int'(v.len); i++) ram_write(v.bq + ADDRW'(i), 32'hDEAD_BEEF);
    for (int i = 0; i < int'(v.len); i++) ram_write(v.ba + ADDRW'(i), v.a[i]);
    for (int i = 0; i < int'(v.len); i++) ram_write(v.bb + ADDRW'(i), v.b[i]);
  endtask

  task automatic start_job(input vec_t v, input bit hold);
    @(negedge clock);
    len = v.len; base_a = v.ba; base_b = v.bb; base_q = v.bq; start = 1'b1;
    @(negedge clock);
    if (hold) begin
      // Held start with different parameters must not disturb the running job.
      len = v.len + 3; base_q = v.bq + 11'd40;
    end else begin
      start = 1'b0;
    end
  endtask

  task automatic run_job(input string nm, input vec_t v, input bit hold);
    int  s_div, s_done, s_we, s_busy;
    bit  seen;
    logic [ADDRW-1:0] ad;
    preload(v);
    div_k  = int'(v.k);
    s_div  = n_div; s_done = n_done; s_we = n_we; s_busy = n_busy;
    start_job(v, hold);
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    repeat (4) @(negedge clock);
    chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
    chk({nm, "_dz_count"}, 64'(dz_count), 64'(v.dz));
    chk({nm, "_div_pulses"}, 64'(n_div - s_div), 64'(v.ndiv));
    chk({nm, "_done_pulses"}, 64'(n_done - s_done), 64'd1);
    chk({nm, "_we_cycles"}, 64'(n_we - s_we), 64'(v.len));
    chk({nm, "_busy_cycles"}, 64'(n_busy - s_busy), 64'(v.cyc));
    for (int i = 0; i < int'(v.len); i++) begin
      ad = v.bq + ADDRW'(i);
      chk($sformatf("%s_q%0d", nm, i), 64'(mem[ad]), 64'(v.q[i]));
    end
  endtask

  initial begin
    int s_div, s_we, s_busy;
    bit seen;

    // Job 1: basic, k=3, 7 cycles/element.
    vecs[0] = '0;
    vecs[0].len = 4; vecs[0].ba = 16; vecs[0].bb = 32; vecs[0].bq = 48;
    vecs[0].a = {32'd0, 32'd7, 32'd81, 32'd100};
    vecs[0].b = {32'd5, 32'd8, 32'd9, 32'd7};
    vecs[0].q = {32'd0, 32'd0, 32'd9, 32'd14};
    vecs[0].k = 3; vecs[0].dz = 0; vecs[0].ndiv = 4; vecs[0].cyc = 28;
    // Job 2: zero divisor in the middle, in place over A, k=2: 6+3+6 cycles.
    vecs[1] = '0;
    vecs[1].len = 3; vecs[1].ba = 64; vecs[1].bb = 80; vecs[1].bq = 64;
    vecs[1].a = {32'd0, 32'd8, 32'd5, 32'd9};
    vecs[1].b = {32'd0, 32'd2, 32'd0, 32'd3};
    vecs[1].q = {32'd0, 32'd4, 32'hFFFF_FFFF, 32'd3};
    vecs[1].k = 2; vecs[1].dz = 1; vecs[1].ndiv = 2; vecs[1].cyc = 15;
    // Job 3: address wrap, in place over A, fastest divider (k=1).
    vecs[2] = '0;
    vecs[2].len = 2; vecs[2].ba = 11'h7FF; vecs[2].bb = 10; vecs[2].bq = 11'h7FF;
    vecs[2].a = {32'd0, 32'd0, 32'd1000, 32'd50};
    vecs[2].b = {32'd0, 32'd0, 32'd10, 32'd5};
    vecs[2].q = {32'd0, 32'd0, 32'd100, 32'd10};
    vecs[2].k = 1; vecs[2].dz = 0; vecs[2].ndiv = 2; vecs[2].cyc = 10;
    // Job 4: full-range dividend, in place over B, k=4.
    vecs[3] = '0;
    vecs[3].len = 1; vecs[3].ba = 300; vecs[3].bb = 310; vecs[3].bq = 310;
    vecs[3].a = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    vecs[3].b = {32'd0, 32'd0, 32'd0, 32'd1};
    vecs[3].q = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    vecs[3].k = 4; vecs[3].dz = 0; vecs[3].ndiv = 1; vecs[3].cyc = 8;
    // Job 5: used with start held high.
    vecs[4] = '0;
    vecs[4].len = 2; vecs[4].ba = 200; vecs[4].bb = 210; vecs[4].bq = 220;
    vecs[4].a = {32'd0, 32'd0, 32'd33, 32'd60};
    vecs[4].b = {32'd0, 32'd0, 32'd11, 32'd6};
    vecs[4].q = {32'd0, 32'd0, 32'd3, 32'd10};
    vecs[4].k = 2; vecs[4].dz = 0; vecs[4].ndiv = 2; vecs[4].cyc = 12;

    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_we1", 64'(ram_we1), 64'd0);
    chk("rst_div_start", 64'(div_start), 64'd0);
    chk("rst_dz_count", 64'(dz_count), 64'd0);
    chk("rst_addr1", 64'(ram_addr1), 64'd0);
    chk("rst_addr2", 64'(ram_addr2), 64'd0);
    chk("rst_wdata1", 64'(ram_wdata1), 64'd0);
    chk("rst_dividend", 64'(div_dividend), 64'd0);
    chk("rst_divisor", 64'(div_divisor), 64'd0);
    reset_n = 1'b1;

    for (int j = 0; j < 4; j++) run_job($sformatf("job%0d", j), vecs[j], 1'b0);

    // len=0 right after a job with dz_count=1: done the next cycle, nothing else.
    run_job("dz_job", vecs[1], 1'b0);
    s_div = n_div; s_we = n_we; s_busy = n_busy;
    @(negedge clock);
    len = '0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);
    chk("len0_dz_cleared", 64'(dz_count), 64'd0);
    @(negedge clock);
    chk("len0_done_drop", 64'(done), 64'd0);
    repeat (2) @(negedge clock);
    chk("len0_div", 64'(n_div - s_div), 64'd0);
    chk("len0_we", 64'(n_we - s_we), 64'd0);
    chk("len0_busy_cycles", 64'(n_busy - s_busy), 64'd0);

    // Start held high for the whole job.
    run_job("hold", vecs[4], 1'b1);

    // Reset while in DIV, then a clean job.
    preload(vecs[0]);
    div_k = 6;
    start_job(vecs[0], 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (div_start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk("rstdiv_launch_seen", 64'(seen), 64'd1);
    @(negedge clock);
    chk("rstdiv_in_div", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstdiv_busy", 64'(busy), 64'd0);
    chk("rstdiv_we1", 64'(ram_we1), 64'd0);
    chk("rstdiv_div_start", 64'(div_start), 64'd0);
    chk("rstdiv_dividend", 64'(div_dividend), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_job("after_rst", vecs[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
